// File: rtl/if_buf_stream_writer_pkg.sv
// Shared widths, flag positions and FSM encoding for the IF buffer stream writer.
package if_buf_stream_writer_pkg;

   localparam int IF_SCRATCH_WIDTH = 16;
   localparam int MEM_ADDR_LEN     = 12;
   localparam int ROW_LEN_W        = 8;

   localparam int END_FLAG_BIT     = IF_SCRATCH_WIDTH;
   localparam int START_FLAG_BIT   = IF_SCRATCH_WIDTH + 1;
   localparam int BUF_W            = IF_SCRATCH_WIDTH + 2;

   localparam logic [1:0] ST_IDLE_ENC = 2'd0;
   localparam logic [1:0] ST_RUN_ENC  = 2'd1;
   localparam logic [1:0] ST_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_RUN  = ST_RUN_ENC,
      ST_DONE = ST_DONE_ENC
   } state_e;

   typedef logic [BUF_W-1:0] buf_word_t;

   function automatic buf_word_t pack_word(input logic                        start_flag,
                                           input logic                        end_flag,
                                           input logic [IF_SCRATCH_WIDTH-1:0] data);
      buf_word_t w;
      w                         = '0;
      w[START_FLAG_BIT]         = start_flag;
      w[END_FLAG_BIT]           = end_flag;
      w[IF_SCRATCH_WIDTH-1:0]   = data;
      return w;
   endfunction

endpackage

// File: rtl/if_buf_stream_writer_skid_fifo.sv
// Two-entry skid FIFO holding returned words (with flags) until the IF buffer accepts them.
module if_skid_fifo
   import if_buf_stream_writer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  buf_word_t  din_i,
   output buf_word_t  head_o,
   output logic       empty_o,
   output logic [1:0] occ_o
);

   buf_word_t  mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] occ_q;
   logic [1:0] occ_d;

   // NOTE: storage is not reset; a slot is only visible once occupancy says it holds data.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      occ_d = occ_q;
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) wr_ptr_q <= ~wr_ptr_q;
         if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (occ_q == 2'd0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/if_buf_stream_writer.sv
// Streams a row_len x row_count window from a 1-cycle source memory into the PE IF buffer,
// tagging each word with row-start / row-end flags and honouring the buffer's full flag.
module if_buf_stream_writer
   import if_buf_stream_writer_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [MEM_ADDR_LEN-1:0]     base_addr,
   input  logic [ROW_LEN_W-1:0]        row_len,
   input  logic [ROW_LEN_W-1:0]        row_count,
   output logic                        mem_ren,
   output logic [MEM_ADDR_LEN-1:0]     mem_raddr,
   input  logic [IF_SCRATCH_WIDTH-1:0] mem_rdata,
   input  logic                        IF_buf_full,
   output logic                        IF_buf_write,
   output logic [BUF_W-1:0]            IF_buf_out,
   output logic                        busy,
   output logic                        done
);

   state_e                  state_q;
   logic [MEM_ADDR_LEN-1:0] addr_q;
   logic [ROW_LEN_W-1:0]    len_q;
   logic [ROW_LEN_W-1:0]    cnt_q;
   logic [ROW_LEN_W-1:0]    word_q;
   logic [ROW_LEN_W-1:0]    row_q;
   logic                    all_issued_q;
   logic                    inflight_q;
   logic [1:0]              flags_q;

   buf_word_t  fifo_head;
   logic       fifo_empty;
   logic [1:0] fifo_occ;
   logic       fifo_pop;
   logic [2:0] slots_used;
   logic       issue;
   logic       last_word;
   logic       last_row;
   logic       drained;

   // A pop this cycle frees its slot in time for the read issued this cycle.
   assign fifo_pop   = !fifo_empty && !IF_buf_full;
   assign slots_used = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, fifo_pop};
   assign issue      = (state_q == ST_RUN) && !all_issued_q && (slots_used < 3'd2);
   assign last_word  = (word_q == len_q - ROW_LEN_W'(1));
   assign last_row   = (row_q  == cnt_q - ROW_LEN_W'(1));
   assign drained    = all_issued_q && (slots_used == 3'd0);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         word_q       <= '0;
         row_q        <= '0;
         all_issued_q <= 1'b0;
         inflight_q   <= 1'b0;
         flags_q      <= 2'b00;
      end else begin
         inflight_q <= issue;
         if (issue) flags_q <= {word_q == '0, last_word};
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q       <= base_addr;
                  len_q        <= row_len;
                  cnt_q        <= row_count;
                  word_q       <= '0;
                  row_q        <= '0;
                  all_issued_q <= 1'b0;
                  state_q      <= (row_len == '0 || row_count == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (issue) begin
                  addr_q <= addr_q + MEM_ADDR_LEN'(1);
                  if (last_word) begin
                     word_q <= '0;
                     row_q  <= row_q + ROW_LEN_W'(1);
                     if (last_row) all_issued_q <= 1'b1;
                  end else begin
                     word_q <= word_q + ROW_LEN_W'(1);
                  end
               end
               if (drained) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   if_skid_fifo u_skid_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .pop_i   (fifo_pop),
      .din_i   (pack_word(flags_q[1], flags_q[0], mem_rdata)),
      .head_o  (fifo_head),
      .empty_o (fifo_empty),
      .occ_o   (fifo_occ)
   );

   assign mem_ren      = issue;
   assign mem_raddr    = addr_q;
   assign IF_buf_write = fifo_pop;
   assign IF_buf_out   = fifo_empty ? '0 : fifo_head;
   assign busy         = (state_q == ST_RUN);
   assign done         = (state_q == ST_DONE);

endmodule

// File: doc/if_buf_stream_writer.md
# if_buf_stream_writer

Producer side of the PE input-feature path. Streams a rectangular window of IF words from a 1-cycle-latency source memory into the IF buffer FIFO that the PE's IF read logic drains, tagging each word with the row-start and row-end flag bits that reader depends on. It sits between the global IF memory and the PE IF buffer, honours the buffer's full flag without dropping data, and sustains one word per cycle when the buffer is not full.

## Interface
- IF_SCRATCH_WIDTH, 16, IF data word width.
- MEM_ADDR_LEN, 12, source memory address width.
- ROW_LEN_W, 8, width of the row-length and row-count operands.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  MEM_ADDR_LEN  first source address; latched on accepted start.
- row_len  in  ROW_LEN_W  words per row; latched on accepted start.
- row_count  in  ROW_LEN_W  rows per transfer; latched on accepted start.
- mem_ren  out  1  source read strobe.
- mem_raddr  out  MEM_ADDR_LEN  source read address.
- mem_rdata  in  IF_SCRATCH_WIDTH  read data, valid exactly one cycle after mem_ren.
- IF_buf_full  in  1  IF buffer cannot accept a write this cycle.
- IF_buf_write  out  1  push strobe to IF buffer.
- IF_buf_out  out  IF_SCRATCH_WIDTH+2  {start_flag, end_flag, data}: bit W+1 = row start, bit W = row end.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the transfer has fully drained.

## Operation
- States: IDLE, RUN, DONE. IDLE -> RUN on start. IDLE -> DONE on start when row_len==0 or row_count==0; no reads, no writes. RUN -> DONE when all row_len*row_count reads are issued, none is in flight, and the skid FIFO is empty. DONE -> IDLE unconditionally.
- start is ignored in RUN and DONE.
- Addresses are linear: base_addr, base_addr+1, …; wrap modulo 2^MEM_ADDR_LEN.
- Word counter (0..row_len-1) and row counter (0..row_count-1) advance per issued read. The flags for each read are computed at issue time and travel with it: start_flag = (word==0), end_flag = (word==row_len-1). With row_len==1 both flags are set.
- Returned data plus its flags are written into a 2-entry skid FIFO. IF_buf_write = FIFO non-empty & !IF_buf_full. IF_buf_out = FIFO head, or 0 when the FIFO is empty.
- Read issue rule: in RUN, with reads remaining and (FIFO occupancy + reads in flight) < 2, counting a pop in the same cycle as freeing a slot. This guarantees no overflow under any full pattern.
- Simultaneous FIFO push and pop are legal and keep occupancy unchanged.

## Timing
- Reset values: mem_ren=0, mem_raddr=0, IF_buf_write=0, IF_buf_out=0, busy=0, done=0, state=IDLE, FIFO empty, counters 0.
- Reset asserted mid-transfer aborts immediately. Any data still in flight is discarded, and no done pulse is issued.
- start accepted at edge of cycle S. mem_ren is high in cycle S+1 with base_addr. First data is captured into the FIFO at the end of S+2. First IF_buf_write occurs in S+3 if not full.
- Steady state: one read and one write per cycle while IF_buf_full is low.
- IF_buf_full is sampled combinationally. A word is pushed only in a cycle with IF_buf_write=1.
- done pulses in the cycle after the last IF_buf_write. busy falls in the same cycle.
- Empty transfer: done is high in S+1. busy never rises.

## Structure
- Shared package holds:
  - flag bit offsets (END_FLAG_BIT = IF_SCRATCH_WIDTH, START_FLAG_BIT = IF_SCRATCH_WIDTH+1);
  - state encoding localparams.
- Sub-module if_skid_fifo: 2-entry, IF_SCRATCH_WIDTH+2 wide, with push, pop, empty, and occupancy outputs. The FSM, counters and issue logic stay in the top module.

## Test plan
- Basic: base=0x010, row_len=3, row_count=2, full=0, mem[a]=a → six writes in consecutive cycles S+3..S+8. Data 0x010..0x015. Flags {10,00,01,10,00,01}. done in S+9.
- Backpressure: same transfer with full high on cycles S+4..S+7 → no write while full, no word lost or duplicated, mem_ren never makes occupancy+inflight exceed 2, order preserved.
- row_len=1, row_count=4 → four writes, each with both flags set.
- Zero length: row_len=0, row_count=5 → done at S+1, mem_ren and IF_buf_write never high.
- Address wrap: base=0xFFE, row_len=4, row_count=1 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-transfer: assert rst low during the 3rd word of 8 → all outputs 0 asynchronously, no done. A fresh start afterwards completes a full, correct transfer.
